uart_frame_rx: RTL

Oversampling UART receiver: the far end of the `series` transmitter's frame (start, 8 data bits LSB first, optional even/odd parity, 1 stop). It runs on the same 16×-baud `clk` as the transmitter and synchronises the asynchronous `rx` pin. Each bit is decided by majority vote of three mid-bit samples, and the received byte is presented on a valid/ready output with parity, framing and overrun status. It sits between the board pin and the command/data consumers.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_sampler.sv | 36 +++
 rtl/uart_frame_rx.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame constants and the parity
// helper used by both ends of the link.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRKWAIT
  } uart_state_e;

  localparam int unsigned UART_DATA_BITS       = 8;
  localparam int unsigned UART_OVERSAMPLE_DFLT = 16;

  // Parity bit for a byte: seed 0 gives even parity, seed 1 gives odd parity.
  function automatic logic uart_parity(input logic seed,
                                       input logic [UART_DATA_BITS-1:0] data);
    return seed ^ (^data);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Pin conditioning for the UART receiver: 2-FF synchroniser, falling-edge
// detect and a 2-of-3 majority over the current and two previous samples.
module uart_rx_sampler (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_rx,
  output logic o_rxs,
  output logic o_fall,
  output logic o_maj
);

  logic r_sync1;
  logic r_sync2;
  logic r_hist1;
  logic r_hist2;

  // Everything resets to the idle-high level so reset release cannot look like a start bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_hist1 <= 1'b1;
      r_hist2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      r_hist1 <= r_sync2;
      r_hist2 <= r_hist1;
    end
  end

  assign o_rxs  = r_sync2;
  assign o_fall = r_hist1 & ~r_sync2;
  assign o_maj  = (r_sync2 & r_hist1) | (r_sync2 & r_hist2) | (r_hist1 & r_hist2);

endmodule

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: oversampling UART receiver with valid/ready byte output.
// Define UART_RX_PARITY_EN for the 11-bit frame with a checked parity bit.
module uart_frame_rx
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE  = UART_OVERSAMPLE_DFLT,
  parameter logic        PARITY_MODE = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned   PW      = $clog2(OVERSAMPLE);
  localparam logic [PW-1:0] PH_MID  = PW'(OVERSAMPLE / 2);
  localparam logic [PW-1:0] PH_LAST = PW'(OVERSAMPLE - 1);
  localparam logic [2:0]    BIDX_LAST = 3'(UART_DATA_BITS - 1);

  logic w_rxs;
  logic w_fall;
  logic w_maj;
  logic w_mid;
  logic w_accept;
  logic w_load_ok;

  uart_state_e               r_state;
  logic [PW-1:0]             r_phase;
  logic [2:0]                r_bidx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] r_dout;
  logic                      r_valid;
  logic                      r_ferr;
  logic                      r_overrun;
  logic                      r_busy;
`ifdef UART_RX_PARITY_EN
  logic                      r_par;
  logic                      r_perr_pend;
  logic                      r_perr;
`endif

  uart_rx_sampler u_sampler (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_rx   (rx),
    .o_rxs  (w_rxs),
    .o_fall (w_fall),
    .o_maj  (w_maj)
  );

  assign w_mid     = (r_phase == PH_MID);
  assign w_accept  = r_valid & dout_ready;
  assign w_load_ok = ~r_valid | w_accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_phase     <= '0;
      r_bidx      <= '0;
      r_shift     <= '0;
      r_dout      <= '0;
      r_valid     <= 1'b0;
      r_ferr      <= 1'b0;
      r_overrun   <= 1'b0;
      r_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par       <= 1'b0;
      r_perr_pend <= 1'b0;
      r_perr      <= 1'b0;
`endif
    end else begin
      r_overrun <= 1'b0;
      if (w_accept) r_valid <= 1'b0;
      r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + PW'(1);

      case (r_state)
        IDLE: begin
          // The edge cycle counts as phase 0, so the counter resumes at 1.
          if (w_fall) begin
            r_state <= START;
            r_busy  <= 1'b1;
            r_phase <= PW'(1);
          end
        end
        START: begin
          if (w_mid) begin
            if (w_maj) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state     <= DATA;
              r_bidx      <= '0;
`ifdef UART_RX_PARITY_EN
              r_par       <= PARITY_MODE;
              r_perr_pend <= 1'b0;
`endif
            end
          end
        end
        DATA: begin
          if (w_mid) begin
            r_shift <= {w_maj, r_shift[UART_DATA_BITS-1:1]};
            r_bidx  <= r_bidx + 3'd1;
`ifdef UART_RX_PARITY_EN
            r_par   <= r_par ^ w_maj;
            if (r_bidx == BIDX_LAST) r_state <= PARITY;
`else
            if (r_bidx == BIDX_LAST) r_state <= STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (w_mid) begin
            r_perr_pend <= (w_maj != r_par);
            r_state     <= STOP;
          end
        end
`endif
        STOP: begin
          if (w_mid) begin
            if (w_load_ok) begin
              r_dout  <= r_shift;
              r_valid <= 1'b1;
              r_ferr  <= ~w_maj;
`ifdef UART_RX_PARITY_EN
              r_perr  <= r_perr_pend;
`endif
            end else begin
              r_overrun <= 1'b1;
            end
            r_state <= w_maj ? IDLE : BRKWAIT;
            r_busy  <= ~w_maj;
          end
        end
        BRKWAIT: begin
          if (w_rxs) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign frame_err  = r_ferr;
  assign overrun    = r_overrun;
  assign busy       = r_busy;
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_perr;
`else
  // No parity bit in this frame format; PARITY_MODE stays on the parameter list unchanged.
  assign parity_err = PARITY_MODE & 1'b0;
`endif

endmodule
